// File: rtl/imm_gen_stage.sv
// imm_gen_stage: decode-stage immediate generator. Extracts and extends the
// immediate of an instruction word, then registers it together with a
// sideband tag behind a valid/ready handshake with an optional skid entry.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. The producer may change its payload freely while valid is low.
// The consumer sees out_valid, imm_ext, out_tag and out_illegal held stable
// while out_valid is high and out_ready is low. out_valid is a pure register
// output. With SKID_EN=1, in_ready is also a pure register output.
module imm_gen_stage #(
  parameter int XLEN    = 32,
  parameter int TAG_W   = 32,
  parameter int SKID_EN = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic [2:0]       imm_src,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  imm_ext,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal
);

  localparam logic [2:0] SRC_I     = 3'b000;
  localparam logic [2:0] SRC_S     = 3'b001;
  localparam logic [2:0] SRC_B     = 3'b010;
  localparam logic [2:0] SRC_J     = 3'b011;
  localparam logic [2:0] SRC_U     = 3'b100;
  localparam logic [2:0] SRC_Z     = 3'b101;
  localparam logic [2:0] SRC_SHAMT = 3'b110;

  // Main register M drives the outputs; skid register K holds one overflow entry.
  logic             r_m_valid;
  logic [XLEN-1:0]  r_m_imm;
  logic [TAG_W-1:0] r_m_tag;
  logic             r_m_ill;
  logic             r_k_valid;
  logic [XLEN-1:0]  r_k_imm;
  logic [TAG_W-1:0] r_k_tag;
  logic             r_k_ill;

  logic [XLEN-1:0]  w_imm;
  logic             w_ill;
  logic [5:0]       w_shamt;
  logic             w_m_free;
  logic             w_accept;
  logic             w_unused_opcode;

  // The opcode field does not select the immediate format; imm_src does.
  assign w_unused_opcode = ^instr[6:0];

  // The shift amount field grows by one bit on 64-bit datapaths.
  assign w_shamt = (XLEN == 64) ? instr[25:20] : {1'b0, instr[24:20]};

  // Combinational immediate extraction and extension to XLEN.
  always_comb begin
    w_imm = '0;
    w_ill = 1'b0;
    case (imm_src)
      SRC_I:     w_imm = {{(XLEN-12){instr[31]}}, instr[31:20]};
      SRC_S:     w_imm = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
      SRC_B:     w_imm = {{(XLEN-12){instr[31]}}, instr[7], instr[30:25],
                          instr[11:8], 1'b0};
      SRC_J:     w_imm = {{(XLEN-20){instr[31]}}, instr[19:12], instr[20],
                          instr[30:21], 1'b0};
      // Sign-extend the 20-bit upper field, then shift it into place; on a
      // 32-bit datapath the shift pushes the extension bits out entirely.
      SRC_U:     w_imm = {{(XLEN-20){instr[31]}}, instr[31:12]} << 12;
      SRC_Z:     w_imm = {{(XLEN-5){1'b0}}, instr[19:15]};
      SRC_SHAMT: w_imm = {{(XLEN-6){1'b0}}, w_shamt};
      default: begin
        w_imm = '0;
        w_ill = 1'b1;
      end
    endcase
  end

  // M can take a new entry when it is empty or handing its entry off now.
  assign w_m_free = ~r_m_valid | out_ready;

  // With the skid entry, ready only falls once K is occupied, so it never
  // depends on out_ready in the same cycle.
  assign in_ready = (SKID_EN != 0) ? ~r_k_valid : w_m_free;

  // Flush discards whatever is presented alongside it.
  assign w_accept = in_valid & in_ready & ~flush;

  // Two-entry FIFO: K always refills M before a new entry can enter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_m_valid <= 1'b0;
      r_m_imm   <= '0;
      r_m_tag   <= '0;
      r_m_ill   <= 1'b0;
      r_k_valid <= 1'b0;
      r_k_imm   <= '0;
      r_k_tag   <= '0;
      r_k_ill   <= 1'b0;
    end else if (flush) begin
      r_m_valid <= 1'b0;
      r_k_valid <= 1'b0;
    end else if (w_m_free) begin
      if (r_k_valid) begin
        r_m_valid <= 1'b1;
        r_m_imm   <= r_k_imm;
        r_m_tag   <= r_k_tag;
        r_m_ill   <= r_k_ill;
        r_k_valid <= 1'b0;
      end else if (w_accept) begin
        r_m_valid <= 1'b1;
        r_m_imm   <= w_imm;
        r_m_tag   <= in_tag;
        r_m_ill   <= w_ill;
      end else begin
        r_m_valid <= 1'b0;
      end
    end else if (w_accept) begin
      r_k_valid <= 1'b1;
      r_k_imm   <= w_imm;
      r_k_tag   <= in_tag;
      r_k_ill   <= w_ill;
    end
  end

  assign out_valid   = r_m_valid;
  assign imm_ext     = r_m_imm;
  assign out_tag     = r_m_tag;
  assign out_illegal = r_m_ill;

endmodule

// File: doc/imm_gen_stage.md
Name: imm_gen_stage

Overview:
- Parametrised, pipelined immediate generator for the decode stage; successor to the combinational sign extender.
- Extracts the immediate from a full instruction word for ImmSrc types I/S/B/J/U plus CSR-uimm and shift-amount, and extends it to XLEN.
- Result is registered behind a valid/ready handshake with a 2-entry skid buffer, so decode can stall without a combinational ready path.
- Sits between instruction fetch/decode and the ID/EX register; carries a sideband tag (PC) alongside each immediate.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64.
TAG_W, 32, width of sideband tag carried with each entry.
SKID_EN, 1, 1 = 2-entry skid buffer; 0 = single output register, in_ready = out_ready | ~out_valid.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
flush  in  1  synchronous pipeline flush, discards all held entries
in_valid  in  1  input entry valid
in_ready  out  1  block can accept an entry this cycle
instr  in  32  full instruction word
imm_src  in  3  immediate type select
in_tag  in  TAG_W  sideband tag (PC)
out_valid  out  1  output entry valid
out_ready  in  1  downstream accepts output this cycle
imm_ext  out  XLEN  extended immediate
out_tag  out  TAG_W  tag of the output entry
out_illegal  out  1  imm_src was 3'b111 for this entry

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: out_valid=0, imm_ext=0, out_tag=0, out_illegal=0, skid entry invalid. in_ready=1 from the first cycle after reset is released.
- Decode is combinational on instr; S = sign bit instr[31]; all sign extension is to XLEN bits.
  - 000 I: S-ext instr[31:20]
  - 001 S: S-ext {instr[31:25], instr[11:7]}
  - 010 B: S-ext {instr[31], instr[7], instr[30:25], instr[11:8], 0}
  - 011 J: S-ext {instr[31], instr[19:12], instr[20], instr[30:21], 0}
  - 100 U: {instr[31:12], 12'b0}; when XLEN=64, bits 63:32 = S
  - 101 Z (CSR uimm): zero-ext instr[19:15]
  - 110 SHAMT: zero-ext instr[24:20] for XLEN=32, instr[25:20] for XLEN=64
  - 111: imm=0, out_illegal=1
- Latency: an entry accepted in cycle N (in_valid & in_ready) appears on the outputs in cycle N+1 at the earliest.
- Output transfer: occurs when out_valid & out_ready. Outputs hold stable while out_valid & ~out_ready.
- Skid buffer (SKID_EN=1): main register M drives the outputs; skid register K holds one overflow entry.
  - in_ready = ~K.valid. This is a registered value with no combinational path from out_ready.
  - Accept while M is empty, or M is draining this cycle: entry goes to M.
  - Accept while M is full and stalled: entry goes to K.
  - M drains and K is valid: K moves to M, K clears. An accept in the same cycle is impossible because in_ready=0.
  - Ordering is strict FIFO; no entry is dropped or duplicated.
- flush: next cycle M.valid=0 and K.valid=0. Flush overrides any simultaneous accept, so an entry presented in the flush cycle is discarded. in_ready=1 the cycle after a flush. Data registers may keep stale values.
- rst during stalled operation: same as flush, and data/tag/illegal outputs are also cleared to 0.
- in_valid=0: no state change other than draining.
- out_valid must never depend combinationally on in_valid.

Test Plan:
- I-type: instr=0xFFF00093, imm_src=000, out_ready=1 -> next cycle out_valid=1, imm_ext=0xFFFFFFFF.
- B and J types, XLEN=32:
  - instr=0xFE000EE3, imm_src=010 -> imm_ext=0xFFFFFFFC.
  - instr=0x008000EF, imm_src=011 -> imm_ext=0x00000008.
- XLEN=64 U and SHAMT:
  - instr=0x800000B7, imm_src=100 -> imm_ext=0xFFFFFFFF80000000.
  - instr=0x03F01013, imm_src=110 -> imm_ext=0x000000000000003F.
- Stall/skid: out_ready=0, present tags 0x100, 0x104, 0x108 back-to-back.
  - 0x100 and 0x104 are accepted; in_ready=0 while 0x108 is held.
  - Raise out_ready -> outputs 0x100, 0x104, 0x108 in order, one per cycle, none lost.
- Flush: M and K full, then assert flush with in_valid=1 (tag 0x200) -> next cycle out_valid=0, in_ready=1, and tag 0x200 never appears.
- Illegal and Z types:
  - imm_src=111 -> imm_ext=0, out_illegal=1.
  - imm_src=101 with instr[19:15]=5'b11111 -> imm_ext=0x1F, out_illegal=0.
